// File: rtl/instruction_fetch_queue.sv
// Pipelined instruction fetch: keeps up to QUEUE_DEPTH reads in flight and buffers returned words with their PCs.
// Optional perf counters are enabled with `define INSTRUCTION_FETCH_QUEUE_PERF_EN.
module instruction_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] PC_INCREMENT = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        system_bus_ready,
  output logic [31:0] system_bus_addr,
  output logic [3:0]  system_bus_byte_enable,
  output logic        system_bus_read_req,
  input  logic [31:0] system_bus_read_data,
  input  logic        system_bus_read_data_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  input  logic        instruction_ready
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_fetched_count,
  output logic [31:0] perf_discarded_count,
  output logic [31:0] perf_stall_count
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_q_data [QUEUE_DEPTH];
  logic [31:0]   r_q_pc   [QUEUE_DEPTH];

  logic [CW:0]   w_credit_used;
  logic          w_read_req;
  logic          w_accept;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_inflight_next;

  // Credits cover both buffered words and reads still on the bus, so a push can never overflow.
  assign w_credit_used   = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_read_req      = !reset && !redirect_valid && (w_credit_used < DEPTH_W);
  assign w_accept        = w_read_req && system_bus_ready;
  assign w_drop          = system_bus_read_data_valid && (redirect_valid || (r_discard != '0));
  assign w_push          = system_bus_read_data_valid && !w_drop;
  assign w_pop           = instruction_valid && instruction_ready && !redirect_valid;
  assign w_inflight_next = r_inflight + CW'(w_accept) - CW'(system_bus_read_data_valid);

  assign system_bus_read_req    = w_read_req;
  assign system_bus_addr        = r_fetch_pc;
  assign system_bus_byte_enable = 4'hf;
  assign instruction_valid      = (r_count != '0);
  assign instruction            = r_q_data[r_rd_ptr];
  assign instruction_pc         = r_q_pc[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      r_inflight <= w_inflight_next;
      if (redirect_valid) begin
        // Every read still outstanding after this cycle belongs to the old path.
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        r_discard  <= w_inflight_next;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + PC_INCREMENT;
        end
        if (w_drop) begin
          r_discard <= r_discard - 1'b1;
        end
        if (w_push) begin
          r_q_data[r_wr_ptr] <= system_bus_read_data;
          r_q_pc[r_wr_ptr]   <= r_resp_pc;
          r_wr_ptr           <= r_wr_ptr + PW'(1);
          r_resp_pc          <= r_resp_pc + PC_INCREMENT;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_discarded;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
      r_perf_stall     <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_drop) r_perf_discarded <= r_perf_discarded + 32'd1;
      if (instruction_ready && !instruction_valid) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched_count   = r_perf_fetched;
  assign perf_discarded_count = r_perf_discarded;
  assign perf_stall_count     = r_perf_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed, table-driven bench for instruction_fetch_queue (QUEUE_DEPTH=4, RESET_PC=0, stride 4).
module tb_instruction_fetch_queue;

  logic        clk;
  logic        reset;
  logic        system_bus_ready;
  logic [31:0] system_bus_addr;
  logic [3:0]  system_bus_byte_enable;
  logic        system_bus_read_req;
  logic [31:0] system_bus_read_data;
  logic        system_bus_read_data_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_ready;
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_count;
  logic [31:0] perf_discarded_count;
  logic [31:0] perf_stall_count;
`endif

  instruction_fetch_queue #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000),
    .PC_INCREMENT(32'd4)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .system_bus_ready          (system_bus_ready),
    .system_bus_addr           (system_bus_addr),
    .system_bus_byte_enable    (system_bus_byte_enable),
    .system_bus_read_req       (system_bus_read_req),
    .system_bus_read_data      (system_bus_read_data),
    .system_bus_read_data_valid(system_bus_read_data_valid),
    .redirect_valid            (redirect_valid),
    .redirect_pc               (redirect_pc),
    .instruction_valid         (instruction_valid),
    .instruction               (instruction),
    .instruction_pc            (instruction_pc),
    .instruction_ready         (instruction_ready)
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched_count        (perf_fetched_count),
    .perf_discarded_count      (perf_discarded_count),
    .perf_stall_count          (perf_stall_count)
`endif
  );

  typedef struct {
    logic        br;
    logic        rdv;
    logic [31:0] raddr;
    logic        redir;
    logic [31:0] rpc;
    logic        ir;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t vq[$];
  int   checks;
  int   failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: each word encodes its own address so order errors are visible.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic br, input logic rdv, input logic [31:0] raddr,
                     input logic redir, input logic [31:0] rpc, input logic ir,
                     input logic req, input logic [31:0] addr, input logic iv,
                     input logic [31:0] ipc);
    vec_t v;
    v.br = br; v.rdv = rdv; v.raddr = raddr; v.redir = redir; v.rpc = rpc; v.ir = ir;
    v.req = req; v.addr = addr; v.iv = iv; v.ipc = ipc;
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    system_bus_ready           = 1'b0;
    system_bus_read_data       = '0;
    system_bus_read_data_valid = 1'b0;
    redirect_valid             = 1'b0;
    redirect_pc                = '0;
    instruction_ready          = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_idle();

    //   br    rdv   raddr    redir rpc      ir      req   addr     iv    ipc
    // Streaming at one instruction per cycle.
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h0,   1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h4,   1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   1'b1,   1'b1, 32'h8,   1'b1, 32'h0);
    add(1'b1, 1'b1, 32'h8,   1'b0, 32'h0,   1'b1,   1'b1, 32'hC,   1'b1, 32'h4);
    // Decode stalls: credits run out, head held.
    add(1'b1, 1'b1, 32'hC,   1'b0, 32'h0,   1'b0,   1'b1, 32'h10,  1'b1, 32'h8);
    add(1'b1, 1'b1, 32'h10,  1'b0, 32'h0,   1'b0,   1'b1, 32'h14,  1'b1, 32'h8);
    add(1'b1, 1'b1, 32'h14,  1'b0, 32'h0,   1'b0,   1'b0, 32'h18,  1'b1, 32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0,   1'b0, 32'h18,  1'b1, 32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b0, 32'h18,  1'b1, 32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0,   1'b1, 32'h18,  1'b1, 32'hC);
    // Bus not ready: address held while queue drains.
    add(1'b0, 1'b1, 32'h18,  1'b0, 32'h0,   1'b0,   1'b0, 32'h1C,  1'b1, 32'hC);
    add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b0, 32'h1C,  1'b1, 32'hC);
    add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h1C,  1'b1, 32'h10);
    add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h1C,  1'b1, 32'h14);
    add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h1C,  1'b1, 32'h18);
    add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h1C,  1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h1C,  1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h1C,  1'b0, 32'h0,   1'b1,   1'b1, 32'h20,  1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h24,  1'b1, 32'h1C);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h28,  1'b0, 32'h0);
    // Redirect with three reads outstanding.
    add(1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1,   1'b0, 32'h2C,  1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h20,  1'b0, 32'h0,   1'b1,   1'b1, 32'h100, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h24,  1'b0, 32'h0,   1'b1,   1'b1, 32'h104, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h28,  1'b0, 32'h0,   1'b1,   1'b1, 32'h108, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1,   1'b1, 32'h10C, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   1'b1,   1'b0, 32'h110, 1'b1, 32'h100);
    // Redirect coinciding with a response and a pop.
    add(1'b1, 1'b1, 32'h108, 1'b1, 32'h200, 1'b1,   1'b0, 32'h110, 1'b1, 32'h104);
    add(1'b1, 1'b1, 32'h10C, 1'b0, 32'h0,   1'b1,   1'b1, 32'h200, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1,   1'b1, 32'h204, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h208, 1'b1, 32'h200);
    // Back-to-back redirects: the second wins.
    add(1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1,   1'b0, 32'h20C, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h204, 1'b1, 32'h400, 1'b1,   1'b0, 32'h300, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h208, 1'b0, 32'h0,   1'b1,   1'b1, 32'h400, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   1'b1,   1'b1, 32'h404, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1,   1'b1, 32'h408, 1'b1, 32'h400);
    // Fill the queue for the mid-stream reset.
    add(1'b1, 1'b1, 32'h404, 1'b0, 32'h0,   1'b0,   1'b1, 32'h40C, 1'b0, 32'h0);
    add(1'b1, 1'b1, 32'h408, 1'b0, 32'h0,   1'b0,   1'b1, 32'h410, 1'b1, 32'h404);
    add(1'b1, 1'b1, 32'h40C, 1'b0, 32'h0,   1'b0,   1'b0, 32'h414, 1'b1, 32'h404);
    add(1'b1, 1'b1, 32'h410, 1'b0, 32'h0,   1'b0,   1'b0, 32'h414, 1'b1, 32'h404);
    add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0,   1'b0, 32'h414, 1'b1, 32'h404);

    #3;
    chk("reset read_req", {31'b0, system_bus_read_req}, 32'd0);
    chk("reset instruction_valid", {31'b0, instruction_valid}, 32'd0);
    chk("reset addr", system_bus_addr, 32'h0);
    chk("reset instruction", instruction, 32'h0);
    chk("reset instruction_pc", instruction_pc, 32'h0);
    chk("byte_enable", {28'b0, system_bus_byte_enable}, 32'hF);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      system_bus_ready           = vq[i].br;
      system_bus_read_data_valid = vq[i].rdv;
      system_bus_read_data       = vq[i].rdv ? word_at(vq[i].raddr) : 32'h0;
      redirect_valid             = vq[i].redir;
      redirect_pc                = vq[i].rpc;
      instruction_ready          = vq[i].ir;
      #1;
      chk($sformatf("row%0d read_req", i), {31'b0, system_bus_read_req}, {31'b0, vq[i].req});
      chk($sformatf("row%0d addr", i), system_bus_addr, vq[i].addr);
      chk($sformatf("row%0d valid", i), {31'b0, instruction_valid}, {31'b0, vq[i].iv});
      if (vq[i].iv) begin
        chk($sformatf("row%0d pc", i), instruction_pc, vq[i].ipc);
        chk($sformatf("row%0d instr", i), instruction, word_at(vq[i].ipc));
      end
      @(negedge clk);
    end

    // Asynchronous reset while the queue is full.
    drive_idle();
    #1;
    chk("full before reset valid", {31'b0, instruction_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset valid", {31'b0, instruction_valid}, 32'd0);
    chk("async reset read_req", {31'b0, system_bus_read_req}, 32'd0);
    chk("async reset addr", system_bus_addr, 32'h0);
    @(negedge clk);
    reset             = 1'b0;
    system_bus_ready  = 1'b1;
    instruction_ready = 1'b1;
    #1;
    chk("restart read_req", {31'b0, system_bus_read_req}, 32'd1);
    chk("restart addr", system_bus_addr, 32'h0);
    chk("restart valid", {31'b0, instruction_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("restart next addr", system_bus_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
